// File: rtl/lsu.sv
// Load/store unit: one outstanding access at a time, translating core byte/half/word
// requests into word-aligned bus transactions and formatting load data back.
module lsu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        st_done,
  output logic        busy,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  type_q;
  logic        sign_q, we_q;
  logic        rvalid_q, st_done_q, mis_q;
  logic        aligned, capture, ld_done, st_done_d, mis_d;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] t,
                                           input logic zext, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    case (t)
      2'b00:   fmt_load = zext ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   fmt_load = zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_store(input logic [31:0] w, input logic [1:0] t);
    case (t)
      2'b00:   fmt_store = {4{w[7:0]}};
      2'b01:   fmt_store = {2{w[15:0]}};
      default: fmt_store = w;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] t, input logic [1:0] a);
    case (t)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  always_comb begin
    case (mem_type)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    ld_done   = 1'b0;
    st_done_d = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Bus responses arriving here are stale and intentionally dropped.
        if (rmem | wmem) begin
          if (aligned) begin
            capture = 1'b1;
            state_d = REQ;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (we_q) begin
            st_done_d = 1'b1;
            state_d   = IDLE;
          end else if (bus_rvalid) begin
            ld_done = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          ld_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      type_q    <= '0;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
      rvalid_q  <= 1'b0;
      st_done_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= ld_done;
      st_done_q <= st_done_d;
      mis_q     <= mis_d;
      if (capture) begin
        addr_q  <= addr;
        wdata_q <= fmt_store(wdata, mem_type);
        type_q  <= mem_type;
        sign_q  <= mem_sign;
        we_q    <= wmem;
      end
      if (ld_done) rdata_q <= fmt_load(bus_rdata, type_q, sign_q, addr_q[1:0]);
    end
  end

  assign bus_req     = (state_q == REQ);
  assign bus_we      = bus_req & we_q;
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign bus_wdata   = wdata_q;
  assign bus_be      = bus_req ? lane_be(type_q, addr_q[1:0]) : 4'b0000;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign st_done     = st_done_q;
  assign misalign    = mis_q;
  assign busy        = (state_q != IDLE) | ((rmem | wmem) & aligned);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one linear sequence of hand-computed load/store scenarios.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rstn;
  logic        rmem, wmem, mem_sign;
  logic [1:0]  mem_type;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        rdata_valid, st_done, busy, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_vec = 0;
  int n_err = 0;
  int req_cycles;

  lsu dut (
    .clk(clk), .rstn(rstn), .rmem(rmem), .wmem(wmem), .mem_type(mem_type),
    .mem_sign(mem_sign), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .st_done(st_done), .busy(busy), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rmem = 0; wmem = 0; mem_type = 2'b00; mem_sign = 0; addr = '0; wdata = '0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    step(); step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rdata_valid}, 32'h0);
    chk("rst_st_done", {31'b0, st_done}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
    rstn = 1;
    step();

    // LB 0x1003 signed, best-case latency
    rmem = 1; mem_type = 2'b00; mem_sign = 0; addr = 32'h1003;
    #1 chk("lb_busy_T", {31'b0, busy}, 32'h1);
    chk("lb_req_T", {31'b0, bus_req}, 32'h0);
    step(); rmem = 0; addr = '0; bus_gnt = 1;
    #1 chk("lb_req_T1", {31'b0, bus_req}, 32'h1);
    chk("lb_addr", bus_addr, 32'h1000);
    chk("lb_be", {28'b0, bus_be}, 32'h8);
    chk("lb_we", {31'b0, bus_we}, 32'h0);
    step(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h80FF_0000;
    #1 chk("lb_req_T2", {31'b0, bus_req}, 32'h0);
    chk("lb_be_T2", {28'b0, bus_be}, 32'h0);
    chk("lb_rvalid_T2", {31'b0, rdata_valid}, 32'h0);
    step(); bus_rvalid = 0; bus_rdata = '0;
    #1 chk("lb_rvalid_T3", {31'b0, rdata_valid}, 32'h1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_busy_T3", {31'b0, busy}, 32'h0);
    step();
    #1 chk("lb_rvalid_T4", {31'b0, rdata_valid}, 32'h0);
    chk("lb_rdata_hold", rdata, 32'hFFFF_FF80);

    // SH 0x2002
    wmem = 1; mem_type = 2'b01; addr = 32'h2002; wdata = 32'h0000_ABCD;
    step(); wmem = 0; addr = '0; wdata = '0; bus_gnt = 1;
    #1 chk("sh_req", {31'b0, bus_req}, 32'h1);
    chk("sh_be", {28'b0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'b0, bus_we}, 32'h1);
    chk("sh_addr", bus_addr, 32'h2000);
    step(); bus_gnt = 0;
    #1 chk("sh_st_done", {31'b0, st_done}, 32'h1);
    chk("sh_busy", {31'b0, busy}, 32'h0);
    chk("sh_req_off", {31'b0, bus_req}, 32'h0);
    step();
    #1 chk("sh_st_done_off", {31'b0, st_done}, 32'h0);

    // LW 0x0006 misaligned
    rmem = 1; mem_type = 2'b10; addr = 32'h0006;
    #1 chk("lw_mis_busy", {31'b0, busy}, 32'h0);
    step(); rmem = 0; addr = '0;
    #1 chk("lw_misalign", {31'b0, misalign}, 32'h1);
    chk("lw_mis_req", {31'b0, bus_req}, 32'h0);
    step();
    #1 chk("lw_misalign_off", {31'b0, misalign}, 32'h0);
    chk("lw_mis_req2", {31'b0, bus_req}, 32'h0);
    chk("lw_mis_busy2", {31'b0, busy}, 32'h0);

    // LHU 0x0002, grant held off 3 cycles, then gnt+rvalid together
    rmem = 1; mem_type = 2'b01; mem_sign = 1; addr = 32'h0002;
    req_cycles = 0;
    step(); rmem = 0; addr = '0;
    for (int i = 0; i < 3; i++) begin
      #1 if (bus_req) req_cycles++;
      step();
    end
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h8001_0000;
    #1 if (bus_req) req_cycles++;
    chk("lhu_be", {28'b0, bus_be}, 32'hC);
    step(); bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
    #1 chk("lhu_req_cycles", req_cycles, 32'd4);
    chk("lhu_rvalid", {31'b0, rdata_valid}, 32'h1);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    chk("lhu_req_off", {31'b0, bus_req}, 32'h0);
    step();

    // rmem+wmem together: store wins; request during REQ is ignored
    rmem = 1; wmem = 1; mem_type = 2'b10; mem_sign = 0; addr = 32'h3000; wdata = 32'h1234_5678;
    step(); wmem = 0; addr = 32'h4000; wdata = 32'hFFFF_FFFF;
    #1 chk("both_we", {31'b0, bus_we}, 32'h1);
    chk("both_addr", bus_addr, 32'h3000);
    chk("both_be", {28'b0, bus_be}, 32'hF);
    step(); rmem = 0; addr = '0; wdata = '0; bus_gnt = 1;
    #1 chk("both_addr_stable", bus_addr, 32'h3000);
    chk("both_wdata", bus_wdata, 32'h1234_5678);
    step(); bus_gnt = 0;
    #1 chk("both_st_done", {31'b0, st_done}, 32'h1);
    chk("both_no_load", {31'b0, rdata_valid}, 32'h0);
    chk("both_req_off", {31'b0, bus_req}, 32'h0);
    step();
    #1 chk("both_no_second", {31'b0, bus_req}, 32'h0);

    // LW 0x5000, reset pulsed in WAIT, late rvalid discarded
    rmem = 1; mem_type = 2'b10; addr = 32'h5000;
    step(); rmem = 0; addr = '0; bus_gnt = 1;
    step(); bus_gnt = 0;
    rstn = 0;
    #1 chk("rstw_req", {31'b0, bus_req}, 32'h0);
    chk("rstw_busy", {31'b0, busy}, 32'h0);
    chk("rstw_rdata", rdata, 32'h0);
    step(); rstn = 1; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
    step(); bus_rvalid = 0; bus_rdata = '0;
    #1 chk("rstw_no_rvalid", {31'b0, rdata_valid}, 32'h0);
    chk("rstw_rdata_after", rdata, 32'h0);
    chk("rstw_req_after", {31'b0, bus_req}, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
